sound_arbiter: RTL
==================

Name: sound_arbiter

Overview:
- Shares the single piezo tone output between the game's audio events: wall bounce, paddle hit, point scored and game over.
- Takes single-cycle event pulses from the game logic and latches each one as pending.
- Grants the tone generator by fixed priority, with preemption, and sequences a three-note game-over jingle.
- Sits between the game logic and the top-level buzzer pin.

Parameters:
- WALL_HALF, 55_697: tone half-period in clk_0 cycles for a wall bounce (~226 Hz).
- PADDLE_HALF, 26_223: half-period for a paddle hit (~480 Hz).
- SCORE_HALF, 51_378: half-period for a point scored (~245 Hz).
- GO_HALF0 / GO_HALF1 / GO_HALF2, 32_111 / 42_813 / 64_222: game-over note half-periods.
- TONE_DUR, 1_258_750: PLAY length in cycles for wall, paddle and score tones (50 ms).
- GO_DUR, 5_035_000: PLAY length per game-over note (200 ms).
- GAP_DUR, 251_750: silent gap after every tone or note (10 ms).

Ports:
- clk_0 in 1: 25.175 MHz clock.
- rst in 1: reset.
- evt_wall in 1: pulse, square hit the top or bottom wall.
- evt_paddle in 1: pulse, square hit a paddle.
- evt_score in 1: pulse, a point was won.
- evt_gameover in 1: pulse, the game ended.
- flush in 1: synchronous abort; clears all pending events and all sound.
- mute in 1: level; forces tone low without changing any timing.
- tone out 1: square wave to the buzzer.
- busy out 1: high in PLAY or GAP.
- active_id out 2: current source; 0 wall, 1 paddle, 2 score, 3 gameover.
- note_idx out 2: current game-over note, 0..2; 0 for all other sources.

Behaviour:
- Reset is asynchronous, active-low on rst; clock is clk_0.
- Reset values: tone=0, busy=0, active_id=0, note_idx=0, pending=0000, state IDLE, all counters 0.
- Pending bits:
  - An evt_x pulse sets pending[x] on the next edge.
  - A pulse arriving in the same cycle its own event is granted is absorbed and does not re-latch.
  - A pulse arriving during that event's own PLAY or GAP is latched and replays afterwards.
- Priority: gameover > score > paddle > wall. Requests are evaluated as (pending | evt) each cycle.
- IDLE:
  - When any request is present, the highest-priority one is granted.
  - The next edge enters PLAY with busy=1, active_id=source, note_idx=0, and that pending bit cleared.
  - Latency: a pulse in cycle N with the block IDLE gives busy=1 and tone=1 at N+1.
- PLAY:
  - Lasts exactly DUR cycles: TONE_DUR, or GO_DUR for gameover.
  - tone starts at 1 and toggles every HALF cycles, where HALF is the parameter for the current source or note.
  - Half-period and duration counters restart at every PLAY entry.
- GAP:
  - Entered after the last PLAY cycle.
  - tone=0, busy stays 1, lasts GAP_DUR cycles.
  - If active_id=3 and note_idx<2: next is PLAY with note_idx+1.
  - Otherwise: next is IDLE, with busy=0 for at least one cycle before the next grant.
- Preemption, checked in PLAY and GAP:
  - A score or gameover request aborts an active wall or paddle sound.
  - A gameover request aborts an active score sound.
  - The next edge enters PLAY of the new source with fresh counters.
  - Equal or lower priority never preempts; those requests stay pending.
  - Stale sounds are dropped: granting score or gameover clears pending wall and paddle; granting gameover also clears pending score.
- flush:
  - Takes priority over everything except reset.
  - Next edge gives state IDLE, pending=0, tone=0, busy=0, active_id=0, note_idx=0.
  - Event pulses in the flush cycle are discarded.
- mute: tone is forced to 0 combinationally at the register output. State, counters, busy and active_id evolve exactly as when unmuted.
- Counter widths are $clog2 of the largest parameter, plus one. There is no wrap inside a phase.
- Reset mid-tone returns to the reset values immediately.

Test Plan:
- Bench parameters for all scenarios: WALL_HALF=2, PADDLE_HALF=3, SCORE_HALF=4, GO_HALF0..2=2,3,4, TONE_DUR=12, GO_DUR=8, GAP_DUR=4.
- Single wall event: evt_wall pulse at cycle 0 -> busy=1, active_id=0 at cycle 1; tone pattern 1,1,0,0,1,1,0,0,1,1,0,0 for 12 cycles; 4 cycles tone=0; busy=0 at cycle 17.
- Simultaneous and queued: evt_wall and evt_paddle in the same cycle -> paddle plays first (active_id=1); wall plays after the GAP plus one IDLE cycle; no tone lost.
- Preemption: evt_score during paddle PLAY cycle 5 -> next cycle active_id=2 with fresh tone 1,1,1,1,0...; pending paddle and wall cleared; busy=0 after 12+4 cycles.
- Gameover jingle: evt_gameover -> note_idx 0,1,2, each note 8 cycles at half-period 2/3/4 with 4-cycle gaps; total busy=36 cycles; an evt_wall during the jingle plays only afterwards.
- Boundary cases:
  - Pulse of the same event in its own grant cycle -> plays once.
  - flush during a GAP with wall pending -> busy=0 next cycle and no wall tone.
  - mute=1 through one paddle tone -> tone stuck at 0; busy duration unchanged (16 cycles).
  - rst low mid-PLAY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sound_arbiter.sv
// Fixed-priority, preemptive arbiter for the piezo tone: wall, paddle, score, game-over jingle.
// Latency: event pulse in cycle N -> busy/tone at N+1; events are latched as pending, never back-pressured.
module sound_arbiter #(
    parameter int WALL_HALF   = 55_697,
    parameter int PADDLE_HALF = 26_223,
    parameter int SCORE_HALF  = 51_378,
    parameter int GO_HALF0    = 32_111,
    parameter int GO_HALF1    = 42_813,
    parameter int GO_HALF2    = 64_222,
    parameter int TONE_DUR    = 1_258_750,
    parameter int GO_DUR      = 5_035_000,
    parameter int GAP_DUR     = 251_750
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       i_evt_wall,
    input  logic       i_evt_paddle,
    input  logic       i_evt_score,
    input  logic       i_evt_gameover,
    input  logic       i_flush,
    input  logic       i_mute,
    output logic       o_tone,
    output logic       o_busy,
    output logic [1:0] o_active_id,
    output logic [1:0] o_note_idx
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_P = max_of(max_of(max_of(WALL_HALF, PADDLE_HALF), max_of(SCORE_HALF, GO_HALF0)),
                                  max_of(max_of(GO_HALF1, GO_HALF2), max_of(max_of(TONE_DUR, GO_DUR), GAP_DUR)));
    localparam int CW = $clog2(MAX_P) + 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_pending, w_pending_nxt, w_req, w_evt, w_clr_mask;
    logic [1:0]      r_active_id, w_active_nxt, r_note_idx, w_note_nxt, w_top;
    logic            r_tone, w_tone_nxt, w_preempt, w_grant;
    logic [CW-1:0]   r_half_cnt, w_half_nxt, r_dur_cnt, w_dur_nxt, w_half_lim, w_dur_lim;

    assign w_evt = {i_evt_gameover, i_evt_score, i_evt_paddle, i_evt_wall};
    assign w_req = r_pending | w_evt;

    always_comb begin
        w_top = 2'd0;
        if (w_req[3])      w_top = 2'd3;
        else if (w_req[2]) w_top = 2'd2;
        else if (w_req[1]) w_top = 2'd1;
    end

    // Granting score/gameover also drops the lower-priority sounds that are now stale.
    always_comb begin
        case (w_top)
            2'd3:    w_clr_mask = 4'b1111;
            2'd2:    w_clr_mask = 4'b0111;
            2'd1:    w_clr_mask = 4'b0010;
            default: w_clr_mask = 4'b0001;
        endcase
    end

    always_comb begin
        case (r_active_id)
            2'd0:    w_half_lim = CW'(WALL_HALF - 1);
            2'd1:    w_half_lim = CW'(PADDLE_HALF - 1);
            2'd2:    w_half_lim = CW'(SCORE_HALF - 1);
            default: begin
                case (r_note_idx)
                    2'd0:    w_half_lim = CW'(GO_HALF0 - 1);
                    2'd1:    w_half_lim = CW'(GO_HALF1 - 1);
                    default: w_half_lim = CW'(GO_HALF2 - 1);
                endcase
            end
        endcase
    end

    assign w_dur_lim = (r_active_id == 2'd3) ? CW'(GO_DUR - 1) : CW'(TONE_DUR - 1);
    assign w_preempt = (r_state != S_IDLE) &&
                       (((r_active_id <= 2'd1) && (w_req[3] || w_req[2])) ||
                        ((r_active_id == 2'd2) && w_req[3]));
    assign w_grant   = ((r_state == S_IDLE) && (|w_req)) || w_preempt;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = w_req;
        w_active_nxt  = r_active_id;
        w_note_nxt    = r_note_idx;
        w_tone_nxt    = r_tone;
        w_half_nxt    = r_half_cnt;
        w_dur_nxt     = r_dur_cnt;
        if (i_flush) begin
            w_state_nxt   = S_IDLE;
            w_pending_nxt = 4'b0000;
            w_active_nxt  = 2'd0;
            w_note_nxt    = 2'd0;
            w_tone_nxt    = 1'b0;
            w_half_nxt    = '0;
            w_dur_nxt     = '0;
        end else if (w_grant) begin
            w_state_nxt   = S_PLAY;
            w_pending_nxt = w_req & ~w_clr_mask;
            w_active_nxt  = w_top;
            w_note_nxt    = 2'd0;
            w_tone_nxt    = 1'b1;
            w_half_nxt    = '0;
            w_dur_nxt     = '0;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (r_dur_cnt == w_dur_lim) begin
                        w_state_nxt = S_GAP;
                        w_tone_nxt  = 1'b0;
                        w_half_nxt  = '0;
                        w_dur_nxt   = '0;
                    end else begin
                        w_dur_nxt = r_dur_cnt + 1'b1;
                        if (r_half_cnt == w_half_lim) begin
                            w_half_nxt = '0;
                            w_tone_nxt = ~r_tone;
                        end else begin
                            w_half_nxt = r_half_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_dur_cnt == CW'(GAP_DUR - 1)) begin
                        w_dur_nxt = '0;
                        if ((r_active_id == 2'd3) && (r_note_idx != 2'd2)) begin
                            w_state_nxt = S_PLAY;
                            w_note_nxt  = r_note_idx + 2'd1;
                            w_tone_nxt  = 1'b1;
                            w_half_nxt  = '0;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_active_nxt = 2'd0;
                            w_note_nxt   = 2'd0;
                        end
                    end else begin
                        w_dur_nxt = r_dur_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pending   <= 4'b0000;
            r_active_id <= 2'd0;
            r_note_idx  <= 2'd0;
            r_tone      <= 1'b0;
            r_half_cnt  <= '0;
            r_dur_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_active_id <= w_active_nxt;
            r_note_idx  <= w_note_nxt;
            r_tone      <= w_tone_nxt;
            r_half_cnt  <= w_half_nxt;
            r_dur_cnt   <= w_dur_nxt;
        end
    end

    // Mute gates only the pin; all timing keeps running underneath.
    assign o_tone      = r_tone & ~i_mute;
    assign o_busy      = (r_state != S_IDLE);
    assign o_active_id = r_active_id;
    assign o_note_idx  = r_note_idx;

endmodule
